// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with load handshake, MSB first.
// Define PISO_PARITY_EN to append an even-parity bit after the data LSB.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [NBITS-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [NBITS-1:0] word;
  logic             accept;

`ifdef PISO_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  always_comb word = {din, even_parity(din)};
`else
  always_comb word = din;
`endif

  // The final-bit cycle doubles as an accept window for gapless streaming.
  assign load_ready = rst_n && (state == IDLE || last);
  assign accept     = load_valid && load_ready;

  // sout is the registered MSB of the shift register.
  assign sout = sr[NBITS-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      sout_valid <= 1'b0;
      last       <= 1'b0;
    end else if (accept) begin
      state      <= SHIFT;
      sr         <= word;
      cnt        <= CNT_W'(NBITS - 1);
      sout_valid <= 1'b1;
      last       <= 1'b0;
    end else if (state == SHIFT) begin
      if (cnt == '0) begin
        state      <= IDLE;
        sr         <= '0;
        sout_valid <= 1'b0;
        last       <= 1'b0;
      end else begin
        sr   <= {sr[NBITS-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
        last <= (cnt == CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: vector table, corner sequences
// and randomized traffic against a bit-queue reference model.
module tb_piso_serializer;
  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             load_ready, sout, sout_valid, last;

  int checks = 0;
  int errors = 0;

  bit          q[$];       // bits still to appear on sout; q[0] is the one shown now
  logic [NB-1:0] sipo = '0; // downstream delay line, MSB ends in the last stage

  typedef struct {
    logic             r;
    logic             lv;
    logic [WIDTH-1:0] d;
    logic             s, v, l, rd;
  } vec_t;
  vec_t tbl[$];

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .din(din), .sout(sout), .sout_valid(sout_valid), .last(last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sout_valid) sipo <= {sipo[NB-2:0], sout};

  function automatic logic [NB-1:0] frame(input logic [WIDTH-1:0] d);
`ifdef PISO_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready before the edge, advance the model,
  // check registered outputs on the falling edge.
  task automatic cycle(input logic r, input logic lv, input logic [WIDTH-1:0] d,
                       output logic rdy);
    logic          m_ready;
    logic [NB-1:0] f;
    rst_n = r; load_valid = lv; din = d;
    #1;
    m_ready = r && (q.size() <= 1);
    rdy = load_ready;
    chk("load_ready", load_ready, m_ready);
    @(posedge clk);
    if (!r) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (lv && m_ready) begin
        f = frame(d);
        for (int i = NB - 1; i >= 0; i--) q.push_back(f[i]);
      end
    end
    @(negedge clk);
    chk("sout", sout, (q.size() > 0) ? q[0] : 1'b0);
    chk("sout_valid", sout_valid, q.size() > 0);
    chk("last", last, q.size() == 1);
  endtask

  task automatic add(input logic r, lv, input logic [WIDTH-1:0] d, input logic s, v, l, rd);
    vec_t t;
    t.r = r; t.lv = lv; t.d = d; t.s = s; t.v = v; t.l = l; t.rd = rd;
    tbl.push_back(t);
  endtask

  initial begin
    logic          rdy;
    logic [WIDTH-1:0] w1;
    logic [2*NB-1:0]  stream, exp_stream;
    int            nvalid, nready, nlast;

    // reset rows (din=FF must not be taken), then one word
    for (int i = 0; i < 3; i++) add(0, 1, 8'hFF, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1);
`ifdef PISO_PARITY_EN
    w1 = 8'h07;
    add(1, 1, 8'h07, 0, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0); add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0); add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0); add(1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0);
`else
    w1 = 8'hA5;
    add(1, 1, 8'hA5, 1, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0); add(1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0); add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0); add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0);
`endif
    add(1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].lv, tbl[i].d, rdy);
      chk("tbl_ready", rdy, tbl[i].rd);
      chk("tbl_sout", sout, tbl[i].s);
      chk("tbl_valid", sout_valid, tbl[i].v);
      chk("tbl_last", last, tbl[i].l);
    end
    chk("sipo_word", sipo, frame(w1));

    // back-to-back: F0 then 0F with load_valid held high
    nvalid = 0; nready = 0; stream = '0;
    for (int c = 0; c < 2 * NB; c++) begin
      if (c == 0)       cycle(1, 1, 8'hF0, rdy);
      else if (c <= NB) cycle(1, 1, 8'h0F, rdy);
      else              cycle(1, 0, 8'h00, rdy);
      if (c >= 1 && c <= NB && rdy) nready++;
      if (sout_valid) nvalid++;
      stream = {stream[2*NB-2:0], sout};
    end
    exp_stream = {frame(8'hF0), frame(8'h0F)};
    chk("b2b_stream", stream, exp_stream);
    chk("b2b_valid_cnt", nvalid, 2 * NB);
    chk("b2b_ready_cnt", nready, 1);
    cycle(1, 0, 8'h00, rdy);
    chk("b2b_idle", sout_valid, 0);

    // stall: requests mid-word must be ignored
    cycle(1, 1, 8'hC3, rdy);
    for (int c = 0; c < 3; c++) begin
      cycle(1, 1, 8'hFF, rdy);
      chk("stall_ready", rdy, 0);
    end
    for (int c = 0; c < NB; c++) cycle(1, 0, 8'h00, rdy);
    chk("stall_word", sipo, frame(8'hC3));
    chk("stall_idle", sout_valid, 0);

    // reset mid-word
    cycle(1, 1, 8'hC3, rdy);
    nlast = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(1, 0, 8'h00, rdy);
      if (last) nlast++;
    end
    cycle(0, 0, 8'h00, rdy);
    chk("rst_mid_valid", sout_valid, 0);
    chk("rst_mid_last", last | (nlast != 0), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready", load_ready, 1);
    cycle(1, 0, 8'h00, rdy);

    // randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++)
      cycle($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, WIDTH'($urandom), rdy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift register with a load handshake. It accepts a WIDTH-bit word and emits it one bit per clock, MSB first, with a valid qualifier. It feeds the serial input of the team's serial-in/parallel-out delay-line registers: after WIDTH valid bits, a downstream WIDTH-stage nonblocking shift chain holds the word with the MSB in its last stage. A last-bit pulse and a load handshake allow gapless word streaming.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; synchronous and active-low.
- load_valid  input  1  producer presents a word on din.
- load_ready  output  1  serializer can accept a word this cycle.
- din  input  WIDTH  parallel word; sampled only on an accept.
- sout  output  1  serial data bit, registered.
- sout_valid  output  1  sout carries a valid bit this cycle, registered.
- last  output  1  high during the final serial bit of a word, registered.

## Operation
- Accept: a word is accepted at a rising edge where load_valid && load_ready.
- State machine:
  - IDLE: load_ready=1, sout_valid=0. On accept, go to SHIFT.
  - SHIFT: stays in SHIFT while bits remain. After the final bit, goes to IDLE if no new accept occurs; on a new accept it stays in SHIFT and restarts the word.
- Datapath:
  - Shift register sr[NBITS-1:0] and bit counter cnt, width $clog2(NBITS+1).
  - NBITS = WIDTH, or WIDTH+1 with the parity option.
  - On accept: sr loads the word; sout=din[WIDTH-1]; cnt=NBITS-1.
  - Each later SHIFT cycle: sr shifts left by one; sout=next bit; cnt decrements.
- last=1 when cnt==0 in SHIFT.
- load_ready = rst_n && (state==IDLE || last). This makes the final-bit cycle an accept window.
- Back-to-back: an accept during the last-bit cycle puts the new word's MSB on sout at the next edge, with no gap and sout_valid held high.
- load_valid without load_ready: ignored. din is not sampled and no state changes. The producer must hold it.
- din may change freely except at an accept edge.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, sr=0, cnt=0, sout=0, sout_valid=0, last=0. load_ready=0 while rst_n is low.
- Latency: accept at edge k gives bit i (MSB = bit 0) on sout in the cycle after edge k+i, for i = 0..NBITS-1.
- sout_valid is high for exactly NBITS cycles per word. last is high in the final one only.
- Reset mid-word: the word is abandoned. All outputs take reset values at that edge and last is not pulsed. After rst_n rises, load_ready=1 immediately.
- Reset and load_valid in the same edge: reset wins and no word is accepted.
- Throughput: one word per NBITS cycles when load_valid is held high.

## Configuration
- PISO_PARITY_EN defined: an even-parity bit (XOR of all din bits) is appended after the data LSB.
  - NBITS = WIDTH+1, and last marks the parity bit.
  - A downstream receiver of length WIDTH then holds the word shifted by one. The receiver must be WIDTH+1 long.
- PISO_PARITY_EN undefined: NBITS = WIDTH, and there is no parity logic or extra cycle.

## Test plan
- Reset: hold rst_n=0 for 3 edges with load_valid=1 and din=8'hFF. Required: sout=0, sout_valid=0, last=0, load_ready=0 throughout, and no word is accepted.
- Single word, WIDTH=8: accept din=8'hA5. Required: sout=1,0,1,0,0,1,0,1 over 8 cycles with sout_valid=1, last=1 only in cycle 8, then sout_valid=0. A downstream 8-stage SIPO then reads 8'hA5.
- Back-to-back: hold load_valid=1 with words 8'hF0 then 8'h0F. Required: 16 contiguous valid bits 1111000000001111, load_ready high only in cycle 8, and a second accept at that edge.
- Stall: load_valid=1 while in SHIFT mid-word. Required: load_ready=0, the word is not accepted, and the current serial stream is not disturbed.
- Reset mid-word: assert rst_n=0 after bit 3 of 8'hC3. Required: sout_valid=0 at the next edge, no last pulse, and load_ready=1 once rst_n=1.
- With PISO_PARITY_EN defined: accept din=8'h07. Required: 9 valid bits 000001111, where the final parity bit is 1, with last on bit 9.
